// File: rtl/ga_eval_pkg.sv
// Shared types and defaults for the GA chromosome evaluation stage.
// Holds the FSM state encoding and the clamped sequence-count helper.
package ga_eval_pkg;

   localparam int N_SEQ_D         = 32;
   localparam int IN_W_D          = 32;
   localparam int OUT_W_D         = 8;
   localparam int CHROM_SEGS_D    = 31;
   localparam int ERR_W_D         = 32;
   localparam int SETTLE_CYCLES_D = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_APPLY   = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_DONE    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   // Number of table entries actually evaluated: the request, capped at the table depth.
   function automatic logic [31:0] clamp_seq(input logic [31:0] req, input logic [31:0] limit);
      clamp_seq = (req > limit) ? limit : req;
   endfunction

endpackage

// File: rtl/error_accumulator.sv
// Per-output-bit mismatch counters; cleared at the start of a run and
// bumped once per sampled input vector.
module error_accumulator
   import ga_eval_pkg::*;
#(
   parameter int OUT_W = OUT_W_D,
   parameter int ERR_W = ERR_W_D
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   sample,
   input  logic [OUT_W-1:0]       mism,
   output logic [OUT_W*ERR_W-1:0] sums
);

   // Counter update: sums never exceed the table depth, so no wrap handling.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sums <= '0;
      end else if (clear) begin
         sums <= '0;
      end else if (sample) begin
         for (int k = 0; k < OUT_W; k++) begin
            sums[ERR_W*k +: ERR_W] <= sums[ERR_W*k +: ERR_W] + {{(ERR_W-1){1'b0}}, mism[k]};
         end
      end else begin
         sums <= sums;
      end
   end

endmodule

// File: rtl/chrom_evaluator.sv
// Evaluation stage: latches a chromosome, steps the evolved circuit through the
// input table and returns per-bit error counts over a start/done/feedback handshake.
module chrom_evaluator
   import ga_eval_pkg::*;
#(
   parameter int N_SEQ         = N_SEQ_D,
   parameter int IN_W          = IN_W_D,
   parameter int OUT_W         = OUT_W_D,
   parameter int CHROM_SEGS    = CHROM_SEGS_D,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_D,
   parameter int ERR_W         = ERR_W_D
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CHROM_SEGS*32-1:0] chrom_seg,
   input  logic [N_SEQ*32-1:0]     input_sequence,
   input  logic [N_SEQ*32-1:0]     expected_output,
   input  logic [N_SEQ*32-1:0]     valid_output,
   input  logic [31:0]             sequences_to_process,
   input  logic                    start_processing_chrom,
   input  logic                    done_processing_feedback,
   output logic                    ready_to_process,
   output logic                    done_processing_chrom,
   output logic [OUT_W*ERR_W-1:0]  error_sum,
   output logic [CHROM_SEGS*32-1:0] chrom_out,
   output logic [IN_W-1:0]         circuit_in,
   input  logic [OUT_W-1:0]        circuit_out
);

   localparam int IDX_W = (N_SEQ > 1) ? $clog2(N_SEQ) : 1;
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   if (ERR_W < $clog2(N_SEQ + 1)) begin : g_err_w_check
      $error("chrom_evaluator: ERR_W too narrow to hold N_SEQ mismatches");
   end
   if (SETTLE_CYCLES < 1) begin : g_settle_check
      $error("chrom_evaluator: SETTLE_CYCLES must be at least 1");
   end

   state_t            state_r;
   logic [IDX_W-1:0]  idx_r;
   logic [31:0]       n_r;
   logic [CNT_W-1:0]  settle_r;
   logic [31:0]       n_load_s;
   logic [IDX_W+4:0]  off_s;
   logic [OUT_W-1:0]  mism_s;
   logic              last_s;
   logic              settled_s;

   // Table entries are 32 bits wide, so the bit offset is idx*32.
   assign off_s     = {idx_r, 5'd0};
   assign n_load_s  = clamp_seq(sequences_to_process, 32'(N_SEQ));
   assign mism_s    = (circuit_out ^ expected_output[off_s +: OUT_W]) & valid_output[off_s +: OUT_W];
   assign last_s    = ({{(32-IDX_W){1'b0}}, idx_r} == (n_r - 32'd1));
   assign settled_s = (settle_r == CNT_W'(SETTLE_CYCLES - 1));

   error_accumulator #(
      .OUT_W (OUT_W),
      .ERR_W (ERR_W)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_r == ST_LOAD),
      .sample (state_r == ST_SAMPLE),
      .mism   (mism_s),
      .sums   (error_sum)
   );

   // Main sequencer: handshake, settle timing, table index and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r               <= ST_IDLE;
         ready_to_process      <= 1'b1;
         done_processing_chrom <= 1'b0;
         chrom_out             <= '0;
         circuit_in            <= '0;
         idx_r                 <= '0;
         n_r                   <= 32'd0;
         settle_r              <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_processing_chrom) begin
                  state_r          <= ST_LOAD;
                  ready_to_process <= 1'b0;
               end
            end
            ST_LOAD: begin
               chrom_out <= chrom_seg;
               idx_r     <= '0;
               n_r       <= n_load_s;
               settle_r  <= '0;
               if (n_load_s == 32'd0) begin
                  state_r               <= ST_DONE;
                  done_processing_chrom <= 1'b1;
               end else begin
                  state_r <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               circuit_in <= input_sequence[off_s +: IN_W];
               if (settled_s) begin
                  settle_r <= '0;
                  state_r  <= ST_SAMPLE;
               end else begin
                  settle_r <= settle_r + CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               if (last_s) begin
                  state_r               <= ST_DONE;
                  done_processing_chrom <= 1'b1;
               end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  state_r <= ST_APPLY;
               end
            end
            ST_DONE: begin
               if (done_processing_feedback) begin
                  done_processing_chrom <= 1'b0;
                  state_r               <= ST_RELEASE;
               end
            end
            // Wait for both levels to drop so a lingering start cannot re-trigger.
            ST_RELEASE: begin
               if (!start_processing_chrom && !done_processing_feedback) begin
                  state_r          <= ST_IDLE;
                  ready_to_process <= 1'b1;
               end
            end
            default: begin
               state_r               <= ST_IDLE;
               ready_to_process      <= 1'b1;
               done_processing_chrom <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chrom_evaluator.sv
// Directed-plus-random bench for chrom_evaluator with a table-level reference model
// of the error sums and the done latency.
module tb_chrom_evaluator;

   localparam int NS = 32;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [991:0]  chrom_seg;
   logic [1023:0] input_sequence;
   logic [1023:0] expected_output;
   logic [1023:0] valid_output;
   logic [31:0]   sequences_to_process;
   logic          start_processing_chrom;
   logic          done_processing_feedback;
   logic          ready_to_process;
   logic          done_processing_chrom;
   logic [255:0]  error_sum;
   logic [991:0]  chrom_out;
   logic [31:0]   circuit_in;
   logic [7:0]    circuit_out;
   int            mode;
   int            vectors = 0;
   int            miscompares = 0;

   chrom_evaluator dut (
      .clk                      (clk),
      .reset                    (reset),
      .chrom_seg                (chrom_seg),
      .input_sequence           (input_sequence),
      .expected_output          (expected_output),
      .valid_output             (valid_output),
      .sequences_to_process     (sequences_to_process),
      .start_processing_chrom   (start_processing_chrom),
      .done_processing_feedback (done_processing_feedback),
      .ready_to_process         (ready_to_process),
      .done_processing_chrom    (done_processing_chrom),
      .error_sum                (error_sum),
      .chrom_out                (chrom_out),
      .circuit_in               (circuit_in),
      .circuit_out              (circuit_out)
   );

   always #5 clk = ~clk;

   // Stand-in evolved circuit: identity, stuck-at-zero, or a byte-fold.
   assign circuit_out = (mode == 0) ? circuit_in[7:0] :
                        (mode == 1) ? 8'h00 :
                        (circuit_in[7:0] ^ circuit_in[15:8] ^ circuit_in[31:24]);

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_circ(input int m, input logic [31:0] x);
      if (m == 0) return x[7:0];
      if (m == 1) return 8'h00;
      return x[7:0] ^ x[15:8] ^ x[31:24];
   endfunction

   function automatic logic [255:0] ref_sums(input int n);
      int            s[8];
      logic [7:0]    mm;
      logic [255:0]  r;
      for (int k = 0; k < 8; k++) s[k] = 0;
      for (int i = 0; i < n; i++) begin
         mm = (ref_circ(mode, input_sequence[32*i +: 32]) ^ expected_output[32*i +: 8])
              & valid_output[32*i +: 8];
         for (int k = 0; k < 8; k++) s[k] += int'(mm[k]);
      end
      for (int k = 0; k < 8; k++) r[32*k +: 32] = s[k];
      return r;
   endfunction

   task automatic rand_chrom();
      for (int s = 0; s < 31; s++) chrom_seg[32*s +: 32] = $urandom;
   endtask

   task automatic rand_tables(input bit identity);
      for (int i = 0; i < NS; i++) begin
         input_sequence[32*i +: 32] = $urandom;
         expected_output[32*i +: 32] = identity ? {24'h0, input_sequence[32*i +: 8]} : $urandom;
         valid_output[32*i +: 32] = identity ? 32'h0000_00FF : $urandom;
      end
      rand_chrom();
   endtask

   task automatic chk_chrom(input string tag, input logic [991:0] exp);
      for (int s = 0; s < 31; s++) chk(tag, chrom_out[32*s +: 32], exp[32*s +: 32]);
   endtask

   // One full run: start, timed wait for done, result checks, then the release handshake.
   task automatic run_eval(input string tag, input int n_req, input bit fb_early);
      int           n;
      int           edges;
      logic [991:0] chrom_exp;
      logic [255:0] sums_exp;
      n = (n_req > NS) ? NS : n_req;
      sums_exp = ref_sums(n);
      @(negedge clk);
      chk({tag, " ready"}, 256'(ready_to_process), 256'd1);
      sequences_to_process = n_req;
      start_processing_chrom = 1'b1;
      chrom_exp = chrom_seg;
      @(posedge clk); #1;
      edges = 0;
      while (!done_processing_chrom && edges < 400) begin
         @(posedge clk); #1;
         edges++;
         if (fb_early && edges == 2) done_processing_feedback = 1'b1;
         if (edges == 4) done_processing_feedback = 1'b0;
         if (edges == 3) rand_chrom();
      end
      chk({tag, " latency"}, 256'(edges), 256'(1 + n * (SC + 1)));
      chk({tag, " sums"}, error_sum, sums_exp);
      chk_chrom({tag, " chrom"}, chrom_exp);
      // Feedback arrives while start is still high.
      done_processing_feedback = 1'b1;
      @(posedge clk); #1;
      chk({tag, " done_clr"}, 256'(done_processing_chrom), 256'd0);
      done_processing_feedback = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, " start_held"}, 256'(ready_to_process), 256'd0);
      chk({tag, " no_rerun"}, 256'(done_processing_chrom), 256'd0);
      start_processing_chrom = 1'b0;
      @(posedge clk); #1;
      chk({tag, " idle_ready"}, 256'(ready_to_process), 256'd1);
      chk({tag, " retained"}, error_sum, sums_exp);
   endtask

   initial begin
      mode = 0;
      reset = 1'b1;
      start_processing_chrom = 1'b0;
      done_processing_feedback = 1'b0;
      sequences_to_process = 32'd0;
      input_sequence = '0;
      expected_output = '0;
      valid_output = '0;
      chrom_seg = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready", 256'(ready_to_process), 256'd1);
      chk("rst done", 256'(done_processing_chrom), 256'd0);
      chk("rst sums", error_sum, 256'd0);
      chk("rst chrom", 256'(|chrom_out), 256'd0);
      chk("rst cin", 256'(circuit_in), 256'd0);
      @(negedge clk);
      reset = 1'b0;

      rand_tables(1'b0);
      run_eval("n0", 0, 1'b0);

      mode = 0;
      rand_tables(1'b1);
      run_eval("ident", 4, 1'b0);
      chk("ident zero", error_sum, 256'd0);

      mode = 1;
      input_sequence = '0;
      expected_output = '0;
      valid_output = '0;
      expected_output[31:0] = 32'h01;
      expected_output[63:32] = 32'h03;
      expected_output[95:64] = 32'hFF;
      valid_output[31:0] = 32'hFF;
      valid_output[63:32] = 32'h01;
      valid_output[95:64] = 32'h80;
      run_eval("errcnt", 3, 1'b0);
      chk("errcnt sum0", 256'(error_sum[31:0]), 256'd2);
      chk("errcnt sum1", 256'(error_sum[63:32]), 256'd0);
      chk("errcnt sum7", 256'(error_sum[255:224]), 256'd1);

      mode = 2;
      rand_tables(1'b0);
      run_eval("clamp", 100, 1'b1);

      for (int r = 0; r < 4; r++) begin
         rand_tables(1'b0);
         run_eval("rand", int'($urandom_range(1, 32)), r[0]);
      end

      // Asynchronous reset in the middle of APPLY.
      rand_tables(1'b0);
      input_sequence[31:0] = 32'hA5A5_0001;
      chrom_seg[31:0] = 32'h0000_0001;
      @(negedge clk);
      sequences_to_process = 32'd8;
      start_processing_chrom = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midrst ready", 256'(ready_to_process), 256'd1);
      chk("midrst done", 256'(done_processing_chrom), 256'd0);
      chk("midrst sums", error_sum, 256'd0);
      chk("midrst chrom", 256'(|chrom_out), 256'd0);
      chk("midrst cin", 256'(circuit_in), 256'd0);
      start_processing_chrom = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      rand_tables(1'b0);
      run_eval("after_rst", 5, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/chrom_evaluator.md
Name: chrom_evaluator

Overview:
- FPGA-side evaluation stage directly downstream of the HPS PIO bank.
- Takes each chromosome, input-sequence table, expected-output table, valid-mask table and sequence count written by the HPS, and latches the chromosome for the evolved circuit.
- Steps the circuit through each input vector and accumulates per-output-bit error counts.
- Returns the counts to the HPS through a four-phase start/done/feedback handshake.

Parameters:
- N_SEQ, 32, number of input-sequence / expected / valid table entries.
- IN_W, 32, width of one input vector presented to the circuit.
- OUT_W, 8, number of circuit output bits evaluated; also the number of error sums.
- CHROM_SEGS, 31, number of 32-bit chromosome segments.
- SETTLE_CYCLES, 4, cycles an input vector is held before the output is sampled; must be ≥1.
- ERR_W, 32, width of each error sum; must be ≥ clog2(N_SEQ+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- chrom_seg  in  CHROM_SEGS*32  flattened chromosome from PIOs; segment i is at [32*i+:32].
- input_sequence  in  N_SEQ*32  flattened input vectors; IN_W LSBs of each entry are used.
- expected_output  in  N_SEQ*32  flattened expected outputs; OUT_W LSBs of each entry are used.
- valid_output  in  N_SEQ*32  flattened care masks; OUT_W LSBs of each entry are used.
- sequences_to_process  in  32  number of entries to evaluate.
- start_processing_chrom  in  1  level request from HPS.
- done_processing_feedback  in  1  HPS acknowledge of done.
- ready_to_process  out  1  high only in IDLE.
- done_processing_chrom  out  1  results valid.
- error_sum  out  OUT_W*ERR_W  error count for output bit k at [ERR_W*k+:ERR_W].
- chrom_out  out  CHROM_SEGS*32  latched chromosome driving the evolved circuit.
- circuit_in  out  IN_W  current input vector.
- circuit_out  in  OUT_W  evolved-circuit response.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, error_sum=0, chrom_out=0, circuit_in=0, idx=0, settle counter=0. A reset mid-run abandons the run; the HPS must re-issue start.
- States: IDLE, LOAD, APPLY, SAMPLE, DONE, RELEASE.
- IDLE:
  - ready_to_process=1.
  - When start=1 is sampled, go to LOAD.
- LOAD (1 cycle):
  - chrom_out <= chrom_seg.
  - All error sums <= 0; idx <= 0.
  - n <= min(sequences_to_process, N_SEQ).
  - Next state is DONE if n==0, else APPLY.
- APPLY:
  - circuit_in = input_sequence[idx], registered.
  - The settle counter counts SETTLE_CYCLES cycles, then the block goes to SAMPLE.
- SAMPLE (1 cycle):
  - mism = (circuit_out ^ exp[idx]) & valid[idx].
  - For each k, error_sum[k] += mism[k].
  - If idx==n-1, go to DONE; otherwise idx++ and return to APPLY.
- Timing:
  - done_processing_chrom rises exactly 1 + n*(SETTLE_CYCLES+1) clock edges after the edge that sampled start.
  - For n=0 it rises after 1 edge.
- DONE:
  - done=1; error_sum and chrom_out are held stable.
  - When feedback=1 is sampled, done <= 0 and go to RELEASE.
- RELEASE: wait until start==0 and feedback==0, then go to IDLE. This prevents a lingering start level from re-triggering.
- Signal stability: start and table inputs are ignored outside IDLE and LOAD. HPS writes during a run do not disturb chrom_out, but table entries are read live during APPLY/SAMPLE, so the HPS must not rewrite tables mid-run.
- Retention: error_sum holds its last result through RELEASE and IDLE, and is cleared only in LOAD.
- Width: a sum cannot exceed N_SEQ, so no wrap or saturation logic is needed. The ERR_W constraint is checked by an elaboration assertion.
- Simultaneous events:
  - feedback=1 arriving before DONE is ignored.
  - start and feedback both high in DONE is handled as a normal DONE→RELEASE transition.

Decomposition:
- Package ga_eval_pkg:
  - state enum.
  - Default N_SEQ, IN_W, OUT_W, CHROM_SEGS and ERR_W constants.
  - Function for the clamped sequence count.
- Sub-module error_accumulator:
  - Inputs: clear, sample enable, mism[OUT_W-1:0].
  - Outputs: OUT_W counters of ERR_W bits.
  - Holds all per-bit counter logic.
- The FSM, settle counter, index and table muxing stay in chrom_evaluator.

Test Plan:
- Reset then idle: ready=1, done=0, all error_sum=0, chrom_out=0.
- n=0: start → done after 1 edge; error_sums=0; feedback → done=0; start low → ready=1.
- Identity circuit (circuit_out=circuit_in[7:0]):
  - Setup: n=4, exp[i]=input[i], valid=0xFF.
  - Response: all sums 0; done after exactly 1+4*5=21 edges.
- Error counting:
  - Setup: circuit_out forced to 0x00; n=3; exp = 0x01, 0x03, 0xFF; valid = 0xFF, 0x01, 0x80.
  - Response: sum0=2, sum1=0, sum7=1, all others 0.
- Clamp: sequences_to_process=100 → 32 entries evaluated; done after 1+32*5=161 edges.
- Robustness:
  - reset asserted mid-APPLY → all outputs return to their reset values immediately.
  - start held high after feedback → no new run until start goes low.
  - Chromosome PIO changed during a run → chrom_out unchanged.
